// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Instruction fetch sequencer. Drives the next-PC value into an
//                external free-running PC register, reads instructions from
//                memory over req/ack and hands them to decode over
//                valid/ready. Execute-stage redirects flush and retarget.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock           in   1  rising-edge clock
//    reset           in   1  synchronous, active-low reset
//    PC_current      in  32  current PC from the PC register
//    PC_next         out 32  next PC to the PC register (combinational)
//    mem_req         out  1  instruction-memory read request
//    mem_addr        out 32  read address, valid while mem_req=1
//    mem_ack         in   1  read completes this cycle
//    mem_rdata       in  32  instruction word, valid with mem_ack
//    instr           out 32  registered instruction to decode
//    instr_pc        out 32  registered address of instr
//    instr_valid     out  1  instr/instr_pc valid
//    instr_ready     in   1  decode accepts the instruction this cycle
//    redirect        in   1  execute requests a PC change (pulse)
//    redirect_target in  32  new PC, valid with redirect
// ============================================================================
module instr_fetch_unit #(
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] PC_current,
  output logic [31:0] PC_next,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] fetch_addr;

  // State register plus the registered decode-side outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= FETCH;
      instr       <= 32'd0;
      instr_pc    <= 32'd0;
      instr_valid <= 1'b0;
      fetch_addr  <= 32'd0;
    end else begin
      state <= state_nxt;
      // Remember the outstanding request address so that a redirect during
      // a wait can keep the stale request stable while the PC moves on.
      if (state == FETCH) begin
        fetch_addr <= PC_current;
      end
      if (redirect) begin
        instr_valid <= 1'b0;
      end else if (state == FETCH && mem_ack) begin
        instr       <= mem_rdata;
        instr_pc    <= PC_current;
        instr_valid <= 1'b1;
      end else if (state == ISSUE && instr_ready) begin
        instr_valid <= 1'b0;
      end
    end
  end

  // Next-state and combinational outputs. PC_next defaults to PC_current so
  // the free-running PC register holds whenever nothing advances it.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_addr  = PC_current;
    PC_next   = PC_current;

    case (state)
      FETCH: begin
        mem_req = 1'b1;
        if (redirect) begin
          // An ack arriving with the redirect completes the old read, so
          // there is nothing left to drain.
          state_nxt = mem_ack ? FETCH : DRAIN;
        end else if (mem_ack) begin
          PC_next   = PC_current + PC_STEP;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (redirect || instr_ready) begin
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        mem_req  = 1'b1;
        mem_addr = fetch_addr;
        if (mem_ack) begin
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase

    if (redirect) begin
      PC_next = redirect_target;
    end

    if (!reset) begin
      mem_req = 1'b0;
      PC_next = 32'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Self-checking bench for instr_fetch_unit. Models the PC
//                register and an instruction memory returning addr ^ KEY;
//                issued instructions are compared against a scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] PC_current;
  logic [31:0] PC_next;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'd0;

  int total = 0;
  int bad   = 0;

  logic [31:0] sb[$];
  logic        draining = 1'b0;

  instr_fetch_unit #(.PC_STEP(32'd4)) dut (
    .clock           (clock),
    .reset           (reset),
    .PC_current      (PC_current),
    .PC_next         (PC_next),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ack         (mem_ack),
    .mem_rdata       (mem_rdata),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target)
  );

  always #5 clock = ~clock;

  // External free-running PC register.
  logic [31:0] pc_reg;
  always_ff @(posedge clock) pc_reg <= PC_next;
  assign PC_current = pc_reg;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, let the combinational
  // outputs settle, then run the scoreboard. Callers check outputs on return,
  // before the rising edge that ends the cycle.
  task automatic drive(input logic rst_n, input logic ack, input logic rdy,
                       input logic redir, input logic [31:0] tgt);
    logic [31:0] e;
    @(negedge clock);
    reset           = rst_n;
    mem_ack         = ack;
    instr_ready     = rdy;
    redirect        = redir;
    redirect_target = tgt;
    mem_rdata       = mem_addr ^ KEY;
    #1;
    if (!rst_n) begin
      sb.delete();
      draining = 1'b0;
    end else begin
      if (instr_valid && (rdy || redir)) begin
        if (sb.size() == 0) begin
          check("unexpected_issue", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          if (!redir) begin
            check("issue_pc", instr_pc, e);
            check("issue_instr", instr, e ^ KEY);
          end
        end
      end
      if (mem_req && ack) begin
        if (!redir && !draining) sb.push_back(mem_addr);
        draining = 1'b0;
      end else if (mem_req && redir) begin
        draining = 1'b1;
      end
    end
  endtask

  initial begin
    // Reset
    drive(0, 0, 0, 0, 0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_pcnext", PC_next, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);

    // Sequential zero-wait; first cycle out of reset requests PC_current
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 1, 0, 0);
      check("seq_valid", {31'd0, instr_valid}, i % 2);
      if (i % 2 == 0) begin
        check("seq_req", {31'd0, mem_req}, 32'd1);
        check("seq_addr", mem_addr, 32'(2 * i));
        check("seq_pcnext", PC_next, 32'(2 * i + 4));
      end else begin
        check("seq_req_issue", {31'd0, mem_req}, 32'd0);
        check("seq_pc_hold", PC_next, 32'(2 * i + 2));
      end
    end

    // Wait states: ack after 3 cycles, then back-pressure for 2 cycles
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 0, 0, 0);
      check("ws_req", {31'd0, mem_req}, 32'd1);
      check("ws_addr", mem_addr, 32'h10);
      check("ws_pc_hold", PC_next, 32'h10);
    end
    drive(1, 1, 0, 0, 0);
    check("ws_addr_ack", mem_addr, 32'h10);
    check("ws_pcnext", PC_next, 32'h14);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, (k == 2), 0, 0);
      check("bp_valid", {31'd0, instr_valid}, 32'd1);
      check("bp_instr", instr, 32'h10 ^ KEY);
      check("bp_pc_hold", PC_current, 32'h14);
    end

    // Redirect in ISSUE with instr_ready=1
    drive(1, 1, 1, 0, 0);
    drive(1, 0, 1, 1, 32'h100);
    check("ri_pcnext", PC_next, 32'h100);
    drive(1, 1, 1, 0, 0);
    check("ri_valid", {31'd0, instr_valid}, 32'd0);
    check("ri_addr", mem_addr, 32'h100);
    drive(1, 0, 1, 0, 0);
    check("ri_instr_pc", instr_pc, 32'h100);

    // Redirect with ack in FETCH, then redirect mid-wait
    drive(1, 1, 0, 1, 32'h10);
    drive(1, 0, 0, 1, 32'h200);
    check("mw_valid", {31'd0, instr_valid}, 32'd0);
    check("mw_addr0", mem_addr, 32'h10);
    check("mw_pcnext", PC_next, 32'h200);
    drive(1, 0, 0, 0, 0);
    check("mw_addr1", mem_addr, 32'h10);
    check("mw_req1", {31'd0, mem_req}, 32'd1);
    check("mw_pc_hold", PC_next, 32'h200);
    drive(1, 1, 0, 0, 0);
    check("mw_addr2", mem_addr, 32'h10);
    drive(1, 1, 1, 0, 0);
    check("mw_valid2", {31'd0, instr_valid}, 32'd0);
    check("mw_addr_new", mem_addr, 32'h200);
    drive(1, 0, 1, 0, 0);

    // Wrap-around
    drive(1, 1, 1, 1, 32'hFFFFFFFC);
    drive(1, 1, 1, 0, 0);
    check("wrap_addr", mem_addr, 32'hFFFFFFFC);
    check("wrap_pcnext", PC_next, 32'h0);
    drive(1, 0, 1, 0, 0);
    check("wrap_pc", PC_current, 32'h0);

    // Reset while in ISSUE
    drive(1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("ri_rst_req", {31'd0, mem_req}, 32'd0);
    check("ri_rst_pcnext", PC_next, 32'd0);
    drive(0, 0, 1, 0, 0);
    check("ri_rst_valid", {31'd0, instr_valid}, 32'd0);
    drive(1, 0, 0, 0, 0);
    check("ri_rel_req", {31'd0, mem_req}, 32'd1);
    check("ri_rel_addr", mem_addr, 32'h0);

    // Reset while in DRAIN, with a stale ack during reset
    drive(1, 0, 0, 1, 32'h40);
    drive(1, 0, 0, 0, 0);
    check("dr_addr", mem_addr, 32'h0);
    check("dr_pc", PC_current, 32'h40);
    drive(0, 1, 0, 0, 0);
    check("dr_rst_req", {31'd0, mem_req}, 32'd0);
    check("dr_rst_pcnext", PC_next, 32'd0);
    drive(1, 0, 0, 0, 0);
    check("dr_rel_valid", {31'd0, instr_valid}, 32'd0);
    check("dr_rel_req", {31'd0, mem_req}, 32'd1);
    check("dr_rel_addr", mem_addr, 32'h0);
    drive(1, 1, 1, 0, 0);
    drive(1, 0, 1, 0, 0);
    check("dr_issue_pc", instr_pc, 32'h0);
    drive(1, 0, 1, 0, 0);
    check("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
